// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card-side command responder.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX       = 3'd1,
        CHECK    = 3'd2,
        WAIT_NCR = 3'd3,
        TX       = 3'd4
    } sd_state_t;

    localparam int          CMD_FRAME_LEN = 48;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;
    localparam logic [5:0]  CMD0_INDEX    = 6'd0;

    // One serial CRC7 step, MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data);
        logic fb;
        fb = data ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0). A clear combined with enable restarts from
// zero and absorbs the current bit in the same cycle.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       data,
    output logic [6:0] crc
);

    // CRC register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= en ? crc7_step(7'h00, data) : 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, data);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD command receiver and R1 responder, all logic on clk.
// Optional received-CRC checking is enabled by defining SD_CRC_CHECK_EN.
module sd_cmd_responder
    import sd_pkg::*;
#(
    parameter int NCR         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_clk_in,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    input  logic [31:0] card_status,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic                   sclk_prev;
    logic                   rise_en;
    logic                   fall_en;
    logic                   cmd_s;

    sd_state_t   state;
    logic [5:0]  bit_cnt;
    logic [5:0]  tx_cnt;
    logic [6:0]  ncr_cnt;
    logic [47:0] rx_sh;
    logic [47:0] tx_sh;

    logic [6:0]  tx_crc;
    logic        tx_load;
    logic        tx_crc_en;
    logic        tx_crc_data;

    // Input synchronisers and sd_clk edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '1;
            cmd_sync  <= '1;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sd_clk_in};
            cmd_sync  <= {cmd_sync[SYNC_STAGES-2:0], cmd_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign rise_en = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign fall_en = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
    assign cmd_s   = cmd_sync[SYNC_STAGES-1];

    assign tx_load     = (state == WAIT_NCR) && fall_en && (ncr_cnt == 7'(NCR - 1));
    assign tx_crc_en   = tx_load || ((state == TX) && fall_en && (tx_cnt < 6'd40));
    assign tx_crc_data = tx_load ? 1'b0 : tx_sh[47];

    sd_crc7 u_tx_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_load),
        .en   (tx_crc_en),
        .data (tx_crc_data),
        .crc  (tx_crc)
    );

`ifdef SD_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       rx_crc_clr;
    logic       rx_crc_en;

    // Start bit plus bits 46..8 feed the receive CRC
    assign rx_crc_clr = (state == IDLE);
    assign rx_crc_en  = rise_en && (((state == IDLE) && !cmd_s) ||
                                    ((state == RX) && (bit_cnt < 6'd40)));

    sd_crc7 u_rx_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_crc_clr),
        .en   (rx_crc_en),
        .data (cmd_s),
        .crc  (rx_crc)
    );
`endif

    // Command/response state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_out   <= 1'b1;
            cmd_oe    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_index <= 6'd0;
            cmd_arg   <= 32'd0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 6'd0;
            tx_cnt    <= 6'd0;
            ncr_cnt   <= 7'd0;
            rx_sh     <= 48'd0;
            tx_sh     <= 48'd0;
        end else begin
            cmd_valid <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_en && !cmd_s) begin
                        rx_sh   <= {rx_sh[46:0], cmd_s};
                        bit_cnt <= 6'd1;
                        state   <= RX;
                        busy    <= 1'b1;
                    end
                end
                RX: begin
                    if (rise_en) begin
                        rx_sh   <= {rx_sh[46:0], cmd_s};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd47) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (rx_sh[47] || !rx_sh[46] || !rx_sh[0]) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
`ifdef SD_CRC_CHECK_EN
                    else if (rx_sh[7:1] != rx_crc) begin
                        crc_err <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
`endif
                    else begin
                        cmd_valid <= 1'b1;
                        cmd_index <= rx_sh[45:40];
                        cmd_arg   <= rx_sh[39:8];
                        ncr_cnt   <= 7'd0;
                        if (rx_sh[45:40] == CMD0_INDEX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_NCR;
                        end
                    end
                end
                WAIT_NCR: begin
                    if (tx_load) begin
                        // Bit 47 goes out now; the shifter holds bits 46..8 next
                        tx_sh   <= {1'b0, cmd_index, card_status, 9'h000};
                        cmd_oe  <= 1'b1;
                        cmd_out <= 1'b0;
                        tx_cnt  <= 6'd1;
                        state   <= TX;
                    end else if (fall_en) begin
                        ncr_cnt <= ncr_cnt + 7'd1;
                    end
                end
                TX: begin
                    if (fall_en) begin
                        tx_cnt <= tx_cnt + 6'd1;
                        if (tx_cnt == 6'd48) begin
                            cmd_oe  <= 1'b0;
                            cmd_out <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else if (tx_cnt == 6'd40) begin
                            cmd_out <= tx_crc[6];
                            tx_sh   <= {tx_crc[5:0], 1'b1, 41'd0};
                        end else begin
                            cmd_out <= tx_sh[47];
                            tx_sh   <= {tx_sh[46:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cmd_oe  <= 1'b0;
                    cmd_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: directed frames plus randomized
// commands checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_sd_cmd_responder;

    localparam int NCR_T = 2;
`ifdef SD_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sd_clk_in = 1'b1;
    logic        cmd_in = 1'b1;
    logic [31:0] card_status = 32'h0000_0000;
    logic        cmd_out, cmd_oe, cmd_valid, crc_err, frame_err, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0, crcerr_cnt = 0, framerr_cnt = 0;

    logic [5:0]  exp_index = 6'd0;
    logic [31:0] exp_arg   = 32'd0;

    sd_cmd_responder #(.NCR(NCR_T), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sd_clk_in(sd_clk_in), .cmd_in(cmd_in),
        .cmd_out(cmd_out), .cmd_oe(cmd_oe), .card_status(card_status),
        .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .crc_err(crc_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid) valid_cnt   <= valid_cnt + 1;
        if (crc_err)   crcerr_cnt  <= crcerr_cnt + 1;
        if (frame_err) framerr_cnt <= framerr_cnt + 1;
    end

    // Reference CRC7 over a 40-bit message, MSB first, polynomial x^7+x^3+1
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [6:0] c;
        logic fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, ref_crc7(head), 1'b1};
    endfunction

    function automatic logic [47:0] make_resp(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] head;
        head = {2'b00, idx, st};
        return {head, ref_crc7(head), 1'b1};
    endfunction

    // 0 accepted, 1 crc error, 2 framing error
    function automatic int classify(input logic [47:0] f);
        if (f[47] != 1'b0 || f[46] != 1'b1 || f[0] != 1'b1) return 2;
        if (CRC_EN && f[7:1] != ref_crc7(f[47:8])) return 1;
        return 0;
    endfunction

    task automatic sd_cycle(input logic host_bit, output logic oe, output logic out);
        @(posedge clk);
        #3;
        sd_clk_in = 1'b0;
        cmd_in    = host_bit;
        #80;
        oe  = cmd_oe;
        out = cmd_out;
        sd_clk_in = 1'b1;
        #80;
    endtask

    task automatic send_bits(input logic [47:0] f, input int hi, input int lo);
        logic oe, out;
        for (int i = hi; i >= lo; i--) sd_cycle(f[i], oe, out);
        cmd_in = 1'b1;
    endtask

    task automatic collect(input int ncyc, input int inject_at, output int first_oe,
                           output int oe_len, output logic [47:0] bits);
        logic oe, out;
        first_oe = 0;
        oe_len   = 0;
        bits     = 48'd0;
        for (int c = 1; c <= ncyc; c++) begin
            sd_cycle((c == inject_at) ? 1'b0 : 1'b1, oe, out);
            if (oe) begin
                if (first_oe == 0) first_oe = c;
                bits = {bits[46:0], out};
                oe_len++;
            end
        end
        cmd_in = 1'b1;
    endtask

    task automatic test_reset;
        checks++; if (cmd_out !== 1'b1)    begin errors++; $display("FAIL reset_cmd_out: got %b want 1", cmd_out); end
        checks++; if (cmd_oe !== 1'b0)     begin errors++; $display("FAIL reset_cmd_oe: got %b want 0", cmd_oe); end
        checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        checks++; if (cmd_index !== 6'd0)  begin errors++; $display("FAIL reset_cmd_index: got %0h want 0", cmd_index); end
        checks++; if (cmd_arg !== 32'd0)   begin errors++; $display("FAIL reset_cmd_arg: got %0h want 0", cmd_arg); end
        checks++; if (crc_err !== 1'b0)    begin errors++; $display("FAIL reset_crc_err: got %b want 0", crc_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_cmd0;
        int v0, fo, len;
        logic [47:0] bits;
        v0 = valid_cnt;
        send_bits(48'h40_0000_0000_95, 47, 28);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cmd0_busy_rx: got %b want 1", busy); end
        send_bits(48'h40_0000_0000_95, 27, 0);
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL cmd0_valid: got %0d pulses want 1", valid_cnt - v0); end
        checks++; if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin errors++; $display("FAIL cmd0_decode: got %0h/%0h want 0/0", cmd_index, cmd_arg); end
        collect(NCR_T + 54, 0, fo, len, bits);
        checks++; if (len != 0) begin errors++; $display("FAIL cmd0_no_resp: got %0d oe cycles want 0", len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cmd0_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_cmd8;
        int v0, fo, len;
        logic [47:0] bits;
        card_status = 32'h0000_0120;
        v0 = valid_cnt;
        send_bits(48'h48_0000_01AA_87, 47, 0);
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL cmd8_valid: got %0d pulses want 1", valid_cnt - v0); end
        checks++; if (cmd_index !== 6'd8 || cmd_arg !== 32'h0000_01AA) begin errors++; $display("FAIL cmd8_decode: got %0h/%0h want 8/1aa", cmd_index, cmd_arg); end
        exp_index = 6'd8; exp_arg = 32'h0000_01AA;
        collect(NCR_T + 54, 0, fo, len, bits);
        checks++; if (fo != NCR_T) begin errors++; $display("FAIL cmd8_ncr: got start at fall %0d want %0d", fo, NCR_T); end
        checks++; if (len != 48) begin errors++; $display("FAIL cmd8_oe_len: got %0d want 48", len); end
        checks++; if (bits !== make_resp(6'd8, 32'h0000_0120)) begin errors++; $display("FAIL cmd8_resp: got %012h want %012h", bits, make_resp(6'd8, 32'h0000_0120)); end
        checks++; if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cmd8_release: got oe=%b out=%b busy=%b want 0 1 0", cmd_oe, cmd_out, busy); end
    endtask

    task automatic test_crc_bad;
        int v0, c0, fo, len;
        logic [47:0] bits;
        v0 = valid_cnt; c0 = crcerr_cnt;
        card_status = 32'h0000_0900;
        send_bits(48'h48_0000_01AA_89, 47, 0);
        collect(NCR_T + 54, 0, fo, len, bits);
        if (CRC_EN) begin
            checks++; if (crcerr_cnt - c0 != 1 || valid_cnt - v0 != 0) begin errors++; $display("FAIL crcbad_flags: got crc=%0d valid=%0d want 1 0", crcerr_cnt - c0, valid_cnt - v0); end
            checks++; if (len != 0) begin errors++; $display("FAIL crcbad_no_resp: got %0d oe cycles want 0", len); end
        end else begin
            checks++; if (crcerr_cnt - c0 != 0 || valid_cnt - v0 != 1) begin errors++; $display("FAIL crcbad_flags: got crc=%0d valid=%0d want 0 1", crcerr_cnt - c0, valid_cnt - v0); end
            checks++; if (bits !== make_resp(6'd8, 32'h0000_0900) || len != 48) begin errors++; $display("FAIL crcbad_resp: got %012h len %0d want %012h len 48", bits, len, make_resp(6'd8, 32'h0000_0900)); end
        end
    endtask

    task automatic test_frame_err;
        int f0, v0, fo, len;
        logic [47:0] bits;
        send_bits(make_cmd(6'd55, 32'hDEAD_0001), 47, 0);
        collect(NCR_T + 54, 0, fo, len, bits);
        exp_index = 6'd55; exp_arg = 32'hDEAD_0001;
        f0 = framerr_cnt; v0 = valid_cnt;
        send_bits(48'h48_0000_01AA_86, 47, 0);
        checks++; if (framerr_cnt - f0 != 1 || valid_cnt - v0 != 0) begin errors++; $display("FAIL frameerr_flags: got frame=%0d valid=%0d want 1 0", framerr_cnt - f0, valid_cnt - v0); end
        checks++; if (cmd_index !== exp_index || cmd_arg !== exp_arg) begin errors++; $display("FAIL frameerr_hold: got %0h/%0h want %0h/%0h", cmd_index, cmd_arg, exp_index, exp_arg); end
        collect(NCR_T + 54, 0, fo, len, bits);
        checks++; if (len != 0) begin errors++; $display("FAIL frameerr_no_resp: got %0d oe cycles want 0", len); end
    endtask

    task automatic test_reset_mid;
        logic oe, out;
        int v0;
        card_status = 32'h1234_5678;
        send_bits(make_cmd(6'd17, 32'h0000_4000), 47, 0);
        for (int c = 1; c <= NCR_T + 19; c++) sd_cycle(1'b1, oe, out);
        @(posedge clk);
        #3;
        sd_clk_in = 1'b0;
        #40;
        checks++; if (cmd_oe !== 1'b1) begin errors++; $display("FAIL rstmid_active: got oe=%b want 1", cmd_oe); end
        rst = 1'b1;
        #1;
        checks++; if (cmd_oe !== 1'b0 || cmd_out !== 1'b1) begin errors++; $display("FAIL rstmid_release: got oe=%b out=%b want 0 1", cmd_oe, cmd_out); end
        #20;
        rst = 1'b0;
        checks++; if (cmd_index !== 6'd0 || cmd_arg !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_regs: got %0h/%0h busy=%b want 0/0 0", cmd_index, cmd_arg, busy); end
        exp_index = 6'd0; exp_arg = 32'd0;
        #20;
        sd_clk_in = 1'b1;
        #80;
        v0 = valid_cnt;
        send_bits(48'h40_0000_0000_95, 47, 0);
        checks++; if (valid_cnt - v0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_cmd0: got valid=%0d busy=%b want 1 0", valid_cnt - v0, busy); end
    endtask

    task automatic test_inject_tx;
        int fo, len, v0;
        logic [47:0] bits;
        logic [31:0] st, arg;
        st = $urandom;
        arg = $urandom;
        card_status = st;
        send_bits(make_cmd(6'd13, arg), 47, 0);
        collect(NCR_T + 54, NCR_T + 10, fo, len, bits);
        checks++; if (bits !== make_resp(6'd13, st) || len != 48 || fo != NCR_T) begin errors++; $display("FAIL inject_resp: got %012h len %0d at %0d want %012h len 48 at %0d", bits, len, fo, make_resp(6'd13, st), NCR_T); end
        v0 = valid_cnt;
        send_bits(make_cmd(6'd0, arg), 47, 0);
        checks++; if (valid_cnt - v0 != 1 || cmd_arg !== arg) begin errors++; $display("FAIL inject_next: got valid=%0d arg=%0h want 1 %0h", valid_cnt - v0, cmd_arg, arg); end
        exp_index = 6'd0; exp_arg = arg;
    endtask

    task automatic test_random;
        int v0, c0, f0, fo, len, kind, etype;
        logic [47:0] f, bits;
        logic [5:0]  idx;
        logic [31:0] arg, st;
        for (int n = 0; n < 8; n++) begin
            idx = (n == 3) ? 6'd0 : 6'($urandom_range(1, 63));
            arg = $urandom;
            st  = $urandom;
            card_status = st;
            f = make_cmd(idx, arg);
            etype = $urandom_range(0, 3);
            if (etype == 1) f[$urandom_range(1, 7)] ^= 1'b1;
            if (etype == 2) f[0] = 1'b0;
            if (etype == 3) f[46] = 1'b0;
            kind = classify(f);
            v0 = valid_cnt; c0 = crcerr_cnt; f0 = framerr_cnt;
            send_bits(f, 47, 0);
            collect(NCR_T + 54, 0, fo, len, bits);
            if (kind == 0) begin
                exp_index = idx;
                exp_arg   = arg;
            end
            checks++; if (valid_cnt - v0 != (kind == 0 ? 1 : 0) || crcerr_cnt - c0 != (kind == 1 ? 1 : 0) || framerr_cnt - f0 != (kind == 2 ? 1 : 0)) begin
                errors++; $display("FAIL rand%0d_flags: got v=%0d c=%0d f=%0d for kind %0d", n, valid_cnt - v0, crcerr_cnt - c0, framerr_cnt - f0, kind);
            end
            checks++; if (cmd_index !== exp_index || cmd_arg !== exp_arg) begin errors++; $display("FAIL rand%0d_decode: got %0h/%0h want %0h/%0h", n, cmd_index, cmd_arg, exp_index, exp_arg); end
            if (kind == 0 && idx != 6'd0) begin
                checks++; if (bits !== make_resp(idx, st) || len != 48 || fo != NCR_T) begin errors++; $display("FAIL rand%0d_resp: got %012h len %0d at %0d want %012h", n, bits, len, fo, make_resp(idx, st)); end
            end else begin
                checks++; if (len != 0) begin errors++; $display("FAIL rand%0d_no_resp: got %0d oe cycles want 0", n, len); end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy: got %b want 0", n, busy); end
        end
    endtask

    initial begin
        #23;
        rst = 1'b0;
        #20;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_crc_bad();
        test_frame_err();
        test_reset_mid();
        test_inject_tx();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
